// File: rtl/audio_codec_cfg_seq.sv
// audio_codec_cfg_seq: WM8731 power-on register loader, single-master I2C writer of a fixed 10-entry table.
// Optional `CFG_AUTOSTART_EN: run the table once automatically when reset is released. GAP_Q must be >= 1.
module audio_codec_cfg_seq #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned I2C_HZ    = 100_000,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned GAP_Q     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] fail_index,
    output logic       audio_i2c_SCLK,
    inout  wire        audio_i2c_SDAT
);

    localparam int unsigned QTR        = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned QW         = (QTR > 1) ? $clog2(QTR) : 1;
    localparam int unsigned RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GW         = (GAP_Q > 1) ? $clog2(GAP_Q) : 1;
    localparam int unsigned LAST_ENTRY = 9;
    localparam logic [7:0]  DEV_BYTE   = {DEV_ADDR, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_DONE, S_FAIL
    } state_t;

    state_t        state_q;
    logic [QW-1:0] qcnt_q;
    logic [1:0]    qph_q;
    logic [2:0]    bit_q;
    logic [1:0]    byte_q;
    logic [7:0]    shift_q;
    logic [3:0]    entry_q;
    logic [RW-1:0] retry_q;
    logic [GW-1:0] gap_q;
    logic          nack_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic [3:0]    fail_index_q;
    logic          sclk_q;
    logic          sda_low_q;

    logic          tick_c;
    logic          go_c;
    logic          sda_in_c;
    logic [15:0]   entry_word_c;
    logic [7:0]    next_byte_c;

    // Each entry packs {reg[6:0], data[8:0]}, so its two halves are exactly the second and third bytes.
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        case (idx)
            4'd0:    table_word = {7'd15, 9'h000};
            4'd1:    table_word = {7'd0,  9'h017};
            4'd2:    table_word = {7'd1,  9'h017};
            4'd3:    table_word = {7'd2,  9'h079};
            4'd4:    table_word = {7'd3,  9'h079};
            4'd5:    table_word = {7'd4,  9'h012};
            4'd6:    table_word = {7'd5,  9'h000};
            4'd7:    table_word = {7'd6,  9'h000};
            4'd8:    table_word = {7'd7,  9'h042};
            4'd9:    table_word = {7'd9,  9'h001};
            default: table_word = 16'h0000;
        endcase
    endfunction

`ifdef CFG_AUTOSTART_EN
    logic auto_q;

    // High for exactly the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (reset) auto_q <= 1'b1;
        else       auto_q <= 1'b0;
    end

    assign go_c = start | auto_q;
`else
    assign go_c = start;
`endif

    assign tick_c       = busy_q && (qcnt_q == QW'(QTR - 1));
    assign sda_in_c     = audio_i2c_SDAT;
    assign entry_word_c = table_word(entry_q);
    assign next_byte_c  = (byte_q == 2'd0) ? entry_word_c[15:8] : entry_word_c[7:0];

    assign audio_i2c_SCLK = sclk_q;
    assign audio_i2c_SDAT = sda_low_q ? 1'b0 : 1'bz;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign fail_index     = fail_index_q;

    // Sequencer: quarter-bit tick generator plus frame FSM; line levels are set on the tick entering each quarter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            qcnt_q       <= '0;
            qph_q        <= 2'd0;
            bit_q        <= 3'd0;
            byte_q       <= 2'd0;
            shift_q      <= 8'h00;
            entry_q      <= 4'd0;
            retry_q      <= '0;
            gap_q        <= '0;
            nack_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            fail_index_q <= 4'd0;
            sclk_q       <= 1'b1;
            sda_low_q    <= 1'b0;
        end else begin
            if (!busy_q || tick_c) qcnt_q <= '0;
            else                   qcnt_q <= qcnt_q + QW'(1);

            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (go_c) begin
                        state_q   <= S_START;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                        entry_q   <= 4'd0;
                        retry_q   <= '0;
                        nack_q    <= 1'b0;
                        qph_q     <= 2'd0;
                        sclk_q    <= 1'b1;
                        sda_low_q <= 1'b0;
                    end
                end

                S_START: begin
                    if (tick_c) begin
                        if (qph_q == 2'd0) begin
                            sda_low_q <= 1'b1;
                            qph_q     <= 2'd1;
                        end else begin
                            state_q   <= S_BYTE;
                            qph_q     <= 2'd0;
                            bit_q     <= 3'd7;
                            byte_q    <= 2'd0;
                            shift_q   <= DEV_BYTE;
                            sclk_q    <= 1'b0;
                            sda_low_q <= ~DEV_BYTE[7];
                        end
                    end
                end

                S_BYTE: begin
                    if (tick_c) begin
                        qph_q <= qph_q + 2'd1;
                        if (qph_q == 2'd1) sclk_q <= 1'b1;
                        if (qph_q == 2'd3) begin
                            sclk_q <= 1'b0;
                            if (bit_q == 3'd0) begin
                                state_q   <= S_ACK;
                                sda_low_q <= 1'b0;
                            end else begin
                                bit_q     <= bit_q - 3'd1;
                                shift_q   <= {shift_q[6:0], 1'b0};
                                sda_low_q <= ~shift_q[6];
                            end
                        end
                    end
                end

                S_ACK: begin
                    if (tick_c) begin
                        qph_q <= qph_q + 2'd1;
                        if (qph_q == 2'd1) sclk_q <= 1'b1;
                        if (qph_q == 2'd3) begin
                            sclk_q <= 1'b0;
                            if (sda_in_c || byte_q == 2'd2) begin
                                state_q   <= S_STOP;
                                nack_q    <= sda_in_c;
                                sda_low_q <= 1'b1;
                            end else begin
                                state_q   <= S_BYTE;
                                byte_q    <= byte_q + 2'd1;
                                bit_q     <= 3'd7;
                                shift_q   <= next_byte_c;
                                sda_low_q <= ~next_byte_c[7];
                            end
                        end
                    end
                end

                S_STOP: begin
                    if (tick_c) begin
                        qph_q <= qph_q + 2'd1;
                        if (qph_q == 2'd0) sclk_q <= 1'b1;
                        if (qph_q == 2'd1) sda_low_q <= 1'b0;
                        if (qph_q == 2'd2) begin
                            state_q <= S_GAP;
                            gap_q   <= '0;
                        end
                    end
                end

                S_GAP: begin
                    if (tick_c) begin
                        gap_q <= gap_q + GW'(1);
                        if (gap_q == GW'(GAP_Q - 1)) begin
                            qph_q  <= 2'd0;
                            nack_q <= 1'b0;
                            if (nack_q && retry_q == RW'(MAX_RETRY)) begin
                                state_q      <= S_FAIL;
                                busy_q       <= 1'b0;
                                error_q      <= 1'b1;
                                fail_index_q <= entry_q;
                            end else if (nack_q) begin
                                state_q <= S_START;
                                retry_q <= retry_q + RW'(1);
                            end else if (entry_q == 4'(LAST_ENTRY)) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_START;
                                entry_q <= entry_q + 4'd1;
                                retry_q <= '0;
                            end
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
